audio_stereo_in: RTL and testbench
==================================

Name: audio_stereo_in

Overview:
- Stereo 1-bit audio receiver; the input-side counterpart of audio_stereo_out.
- Takes two 1-bit pulse-density or PWM bitstreams (left, right), typically from an external modulator or looped back from audio_stereo_out.
- Decimates each stream by counting ones over a fixed window of WINDOW clocks.
- Presents the result as packed stereo PCM {left, right} with a level-held ready and acknowledge handshake, for a PCM consumer in the same clock domain.

Parameters:
- WIDTH, 8, bits per channel sample.
- WINDOW, 255, clocks per decimation window; legal range 2..2^WIDTH-1, so a full-ones window fits in WIDTH bits.
- SYNC_STAGES, 2, flip-flop synchronizer depth on each bitstream input; minimum 2.

Ports:
- clk_audio  in  1  bitstream sample clock; all logic on rising edge.
- aclr  in  1  reset, synchronous, active-low; sampled on rising edge of clk_audio.
- enable  in  1  1 = accumulate windows; 0 = window counter and accumulators held at 0.
- left  in  1  left-channel bitstream, asynchronous to clk_audio.
- right  in  1  right-channel bitstream, asynchronous to clk_audio.
- stereo_pcm  out  2*WIDTH  {left_sample, right_sample}; left in the MSBs.
- stereo_pcm_rdy  out  1  sample valid; held until acknowledged.
- stereo_pcm_ack  in  1  consumer accepts stereo_pcm.
- overrun  out  1  sticky: an unacknowledged sample was overwritten.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset (aclr=0 at an edge): sync chains, win_cnt, l_acc and r_acc go to 0; stereo_pcm=0, stereo_pcm_rdy=0, overrun=0. Reset overrides all other inputs, including mid-window. Outputs hold their reset values until the first window completes.
- Synchronizer: left and right each pass through SYNC_STAGES flops. l_s and r_s are the last-stage outputs. Input-to-accumulate latency is SYNC_STAGES cycles.
- Window counter win_cnt (width clog2(WINDOW)):
  - With enable=1, counts 0..WINDOW-1 and wraps to 0.
  - With enable=0, win_cnt, l_acc and r_acc are forced to 0 at each edge. A partial window is discarded. Output registers are unaffected.
- Accumulators (WIDTH bits each): with enable=1 and win_cnt < WINDOW-1, l_acc += l_s and r_acc += r_s. No overflow is possible because WINDOW ≤ 2^WIDTH-1.
- Window completion occurs on an edge where enable=1 and win_cnt=WINDOW-1:
  - stereo_pcm <= {l_acc+l_s, r_acc+r_s}, so the final sample is included.
  - l_acc, r_acc, win_cnt <= 0.
  - stereo_pcm_rdy <= 1.
  - Result: the first sample appears WINDOW+SYNC_STAGES edges after enable rises, then every WINDOW edges.
- Handshake:
  - stereo_pcm_rdy=1 and stereo_pcm_ack=1 at an edge with no completion: rdy <= 0.
  - ack while rdy=0 is ignored.
  - stereo_pcm is stable while rdy=1, except on a completion.
- Simultaneous completion and ack (rdy=1): the new sample is loaded, rdy stays 1, overrun is unchanged. This counts as a transfer, not a loss.
- Completion with rdy=1 and ack=0: stereo_pcm is overwritten with the new sample, rdy stays 1, overrun <= 1.
- overrun clearing:
  - overrun_clr=1 clears overrun at the edge.
  - If a new overrun event occurs at the same edge, set wins and overrun stays 1.
- Scaling: a PWM input with on-count N per period WINDOW yields sample N for any window phase, because a sliding sum over a periodic signal is constant. This allows direct loopback from audio_stereo_out.

Test Plan:
1. Reset, then enable=1 with left=1 and right=0 held constant -> first rdy pulse at edge WINDOW+2 after enable; stereo_pcm=16'hFF00; overrun=0.
2. Loopback of 255-period PWM with left on-count 127 and right 0 (acked each sample) -> stereo_pcm=16'h7F00 every 255 cycles from the second window on. Then right=127 -> 16'h7F7F; then both 0 -> 16'h0000.
3. No ack across two completions -> rdy stays 1, stereo_pcm shows the second sample, overrun=1. Pulse overrun_clr -> overrun=0 while rdy is still 1.
4. Assert ack on exactly the completion edge (rdy=1) -> new sample loaded, rdy=1, overrun=0. Ack again one cycle later -> rdy=0.
5. Drop enable at win_cnt=100, hold 10 cycles, re-enable with left=1 -> next sample is 8'hFF, i.e. the full new window with no partial carry-over; previous stereo_pcm and rdy are retained while disabled.
6. Assert aclr=0 for one cycle mid-window with rdy=1 and overrun=1 -> next cycle all outputs are 0, and the next sample appears WINDOW+SYNC_STAGES edges after reset release.

Source files
------------

// File: rtl/audio_stereo_in.sv
`default_nettype none
// ============================================================================
// audio_stereo_in: stereo 1-bit bitstream receiver, ones-count decimation to
// packed PCM {left, right} with ready/ack handshake and sticky overrun.
// Revision: 1.0
// ============================================================================
module audio_stereo_in #(
  parameter int WIDTH       = 8,
  parameter int WINDOW      = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_audio,
  input  logic               aclr,
  input  logic               enable,
  input  logic               left,
  input  logic               right,
  output logic [2*WIDTH-1:0] stereo_pcm,
  output logic               stereo_pcm_rdy,
  input  logic               stereo_pcm_ack,
  output logic               overrun,
  input  logic               overrun_clr
);

  localparam int              CNT_W    = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

  logic [SYNC_STAGES-1:0] l_sync_q, l_sync_d;
  logic [SYNC_STAGES-1:0] r_sync_q, r_sync_d;
  logic [SYNC_STAGES-1:0] en_sync_q, en_sync_d;
  logic [CNT_W-1:0]       win_cnt_q, win_cnt_d;
  logic [WIDTH-1:0]       l_acc_q, l_acc_d;
  logic [WIDTH-1:0]       r_acc_q, r_acc_d;
  logic [2*WIDTH-1:0]     pcm_q, pcm_d;
  logic                   rdy_q, rdy_d;
  logic                   ovr_q, ovr_d;

  logic                   w_l_s;
  logic                   w_r_s;
  logic                   w_en;
  logic                   w_done;
  logic [WIDTH-1:0]       w_l_sum;
  logic [WIDTH-1:0]       w_r_sum;

  // Enable is delayed by the same depth as the data so a window starts exactly
  // when the first synchronized sample taken after enable reaches the adders.
  assign w_l_s   = l_sync_q[SYNC_STAGES-1];
  assign w_r_s   = r_sync_q[SYNC_STAGES-1];
  assign w_en    = en_sync_q[SYNC_STAGES-1];
  assign w_done  = w_en && (win_cnt_q == LAST_CNT);
  assign w_l_sum = l_acc_q + {{(WIDTH-1){1'b0}}, w_l_s};
  assign w_r_sum = r_acc_q + {{(WIDTH-1){1'b0}}, w_r_s};

  always_comb begin
    l_sync_d  = {l_sync_q[SYNC_STAGES-2:0], left};
    r_sync_d  = {r_sync_q[SYNC_STAGES-2:0], right};
    en_sync_d = {en_sync_q[SYNC_STAGES-2:0], enable};
    win_cnt_d = win_cnt_q;
    l_acc_d   = l_acc_q;
    r_acc_d   = r_acc_q;
    pcm_d     = pcm_q;
    rdy_d     = rdy_q;
    ovr_d     = ovr_q;

    if (!w_en) begin
      win_cnt_d = '0;
      l_acc_d   = '0;
      r_acc_d   = '0;
    end else if (w_done) begin
      win_cnt_d = '0;
      l_acc_d   = '0;
      r_acc_d   = '0;
      pcm_d     = {w_l_sum, w_r_sum};
    end else begin
      win_cnt_d = win_cnt_q + CNT_W'(1);
      l_acc_d   = w_l_sum;
      r_acc_d   = w_r_sum;
    end

    // A completion coinciding with ack is a transfer; without ack it is a loss.
    if (w_done) begin
      rdy_d = 1'b1;
    end else if (rdy_q && stereo_pcm_ack) begin
      rdy_d = 1'b0;
    end

    if (w_done && rdy_q && !stereo_pcm_ack) begin
      ovr_d = 1'b1;
    end else if (overrun_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_audio) begin
    if (!aclr) begin
      l_sync_q  <= '0;
      r_sync_q  <= '0;
      en_sync_q <= '0;
      win_cnt_q <= '0;
      l_acc_q   <= '0;
      r_acc_q   <= '0;
      pcm_q     <= '0;
      rdy_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      l_sync_q  <= l_sync_d;
      r_sync_q  <= r_sync_d;
      en_sync_q <= en_sync_d;
      win_cnt_q <= win_cnt_d;
      l_acc_q   <= l_acc_d;
      r_acc_q   <= r_acc_d;
      pcm_q     <= pcm_d;
      rdy_q     <= rdy_d;
      ovr_q     <= ovr_d;
    end
  end

  assign stereo_pcm     = pcm_q;
  assign stereo_pcm_rdy = rdy_q;
  assign overrun        = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_stereo_in.sv
`default_nettype none
// ============================================================================
// tb_audio_stereo_in: scoreboard bench with a queue-based window reference model.
// Revision: 1.0
// ============================================================================
module tb_audio_stereo_in;

  localparam int WIDTH       = 8;
  localparam int WINDOW      = 255;
  localparam int SYNC_STAGES = 2;

  logic        clk_audio = 1'b0;
  logic        aclr, enable, left, right, stereo_pcm_ack, overrun_clr;
  logic [15:0] stereo_pcm;
  logic        stereo_pcm_rdy, overrun;

  always #5 clk_audio = ~clk_audio;

  audio_stereo_in #(
    .WIDTH(WIDTH), .WINDOW(WINDOW), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk_audio      (clk_audio),
    .aclr           (aclr),
    .enable         (enable),
    .left           (left),
    .right          (right),
    .stereo_pcm     (stereo_pcm),
    .stereo_pcm_rdy (stereo_pcm_rdy),
    .stereo_pcm_ack (stereo_pcm_ack),
    .overrun        (overrun),
    .overrun_clr    (overrun_clr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: inputs reach the window after SYNC_STAGES edges; a window
  // is a list of effective samples, summed once it holds WINDOW entries.
  logic [2:0]  dly[$];
  logic [1:0]  win[$];
  logic [15:0] sbq[$];
  logic        m_rdy = 1'b0;
  logic        m_ovr = 1'b0;
  logic [15:0] m_pcm = '0;
  bit          m_valid = 1'b0;
  int          m_cmpl = 0;

  initial begin
    logic [2:0]  eff;
    bit          done, acc;
    int          ls, rs;
    logic [15:0] np;
    forever begin
      @(posedge clk_audio);
      if (aclr === 1'b0) begin
        dly.delete();
        for (int i = 0; i < SYNC_STAGES; i++) dly.push_back(3'b000);
        win.delete();
        m_rdy = 1'b0; m_ovr = 1'b0; m_pcm = '0; m_valid = 1'b1;
      end else if (m_valid) begin
        eff = dly.pop_front();
        dly.push_back({enable, left, right});
        done = 1'b0;
        np = '0;
        if (!eff[2]) begin
          win.delete();
        end else begin
          win.push_back(eff[1:0]);
          if (win.size() == WINDOW) begin
            ls = 0; rs = 0;
            foreach (win[i]) begin
              ls += int'(win[i][1]);
              rs += int'(win[i][0]);
            end
            np = {8'(ls), 8'(rs)};
            done = 1'b1;
            win.delete();
            m_cmpl++;
          end
        end
        acc = m_rdy && stereo_pcm_ack;
        if (acc) sbq.push_back(m_pcm);
        if (done && m_rdy && !stereo_pcm_ack) m_ovr = 1'b1;
        else if (overrun_clr) m_ovr = 1'b0;
        if (done) begin
          m_pcm = np; m_rdy = 1'b1;
        end else if (acc) begin
          m_rdy = 1'b0;
        end
      end
    end
  end

  // Monitor: every accepted sample is popped from the scoreboard.
  initial begin
    bit          pend;
    logic [15:0] pv;
    pend = 1'b0; pv = '0;
    forever begin
      @(negedge clk_audio);
      if (m_valid) begin
        if (pend) begin
          if (sbq.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL sb_accept: got 0x%0h, expected no transfer (queue empty)", pv);
          end else begin
            chk("sb_accept", 32'(pv), 32'(sbq.pop_front()));
          end
        end
        chk("rdy", 32'(stereo_pcm_rdy), 32'(m_rdy));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("pcm", 32'(stereo_pcm), 32'(m_pcm));
        pend = stereo_pcm_rdy && stereo_pcm_ack && aclr;
        pv = stereo_pcm;
      end
    end
  end

  int   data_mode, ack_mode, lon, ron, pc;
  bit   clr_rand;
  logic l_const, r_const;

  task automatic drive();
    case (data_mode)
      0:       begin left = l_const; right = r_const; end
      1:       begin left = (pc < lon); right = (pc < ron); end
      default: begin left = 1'($urandom_range(0, 1)); right = 1'($urandom_range(0, 1)); end
    endcase
    case (ack_mode)
      0:       stereo_pcm_ack = 1'b0;
      1:       stereo_pcm_ack = stereo_pcm_rdy;
      default: stereo_pcm_ack = 1'($urandom_range(0, 1));
    endcase
    overrun_clr = clr_rand ? ($urandom_range(0, 15) == 0) : 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_audio);
    #2;
    pc = (pc + 1) % WINDOW;
    drive();
  endtask

  task automatic wait_rdy(input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 2 * WINDOW + 20 && !seen; k++) begin
      tick();
      if (stereo_pcm_rdy === 1'b1) seen = 1'b1;
    end
    chk(nm, 32'(seen), 32'd1);
  endtask

  task automatic wait_cmpl(input int n, input string nm);
    int target = m_cmpl + n;
    for (int k = 0; k < n * (WINDOW + 20) + 20 && m_cmpl < target; k++) tick();
    chk(nm, 32'(m_cmpl >= target), 32'd1);
  endtask

  task automatic wait_win(input int sz, input string nm);
    for (int k = 0; k < 2 * WINDOW + 20 && win.size() != sz; k++) tick();
    chk(nm, 32'(win.size()), 32'(sz));
  endtask

  initial begin
    int n, off;
    bit seen;
    aclr = 1'b0; enable = 1'b0; left = 1'b0; right = 1'b0;
    stereo_pcm_ack = 1'b0; overrun_clr = 1'b0;
    data_mode = 0; ack_mode = 0; clr_rand = 1'b0;
    l_const = 1'b0; r_const = 1'b0; lon = 0; ron = 0; pc = 0;

    repeat (3) tick();
    chk("reset_pcm", 32'(stereo_pcm), 32'h0);
    chk("reset_rdy", 32'(stereo_pcm_rdy), 32'h0);
    chk("reset_ovr", 32'(overrun), 32'h0);

    // First window after enable: full ones on left.
    aclr = 1'b1; enable = 1'b1; l_const = 1'b1; r_const = 1'b0; drive();
    n = 0; seen = 1'b0;
    while (!seen && n < 400) begin
      tick(); n++;
      if (stereo_pcm_rdy === 1'b1) seen = 1'b1;
    end
    chk("first_rdy_edge", 32'(n), 32'(WINDOW + SYNC_STAGES));
    chk("first_pcm", 32'(stereo_pcm), 32'hFF00);
    chk("first_ovr", 32'(overrun), 32'h0);

    // PWM loopback at arbitrary phase.
    data_mode = 1; ack_mode = 1; lon = 127; ron = 0; drive();
    repeat (3) wait_rdy("pwm_rdy");
    chk("pwm_7f00", 32'(stereo_pcm), 32'h7F00);
    ron = 127;
    repeat (3) wait_rdy("pwm_rdy");
    chk("pwm_7f7f", 32'(stereo_pcm), 32'h7F7F);
    lon = 0; ron = 0;
    repeat (3) wait_rdy("pwm_rdy");
    chk("pwm_0000", 32'(stereo_pcm), 32'h0000);

    // Overrun on unacknowledged completions, then clear while rdy held.
    data_mode = 2; ack_mode = 0; drive();
    wait_cmpl(2, "ovr_cmpl");
    chk("ovr_rdy", 32'(stereo_pcm_rdy), 32'h1);
    chk("ovr_set", 32'(overrun), 32'h1);
    overrun_clr = 1'b1; tick();
    chk("ovr_clr", 32'(overrun), 32'h0);
    chk("ovr_clr_rdy", 32'(stereo_pcm_rdy), 32'h1);

    // Ack exactly on the completion edge.
    data_mode = 0; l_const = 1'b0; r_const = 1'b1; drive();
    wait_cmpl(3, "ackc_cmpl");
    overrun_clr = 1'b1; tick();
    wait_win(WINDOW - 1, "ackc_win");
    stereo_pcm_ack = 1'b1; tick();
    chk("ackc_rdy", 32'(stereo_pcm_rdy), 32'h1);
    chk("ackc_ovr", 32'(overrun), 32'h0);
    chk("ackc_pcm", 32'(stereo_pcm), 32'h00FF);
    stereo_pcm_ack = 1'b1; tick();
    chk("ackc_drop", 32'(stereo_pcm_rdy), 32'h0);

    // Disable mid-window: partial window discarded, outputs retained.
    wait_cmpl(1, "dis_cmpl");
    l_const = 1'b1; r_const = 1'b0; drive();
    wait_win(100, "dis_win");
    enable = 1'b0;
    repeat (10) tick();
    chk("dis_rdy", 32'(stereo_pcm_rdy), 32'h1);
    chk("dis_pcm", 32'(stereo_pcm), 32'h00FF);
    ack_mode = 1; tick(); tick();
    enable = 1'b1;
    wait_rdy("reen_rdy");
    chk("reen_pcm", 32'(stereo_pcm), 32'hFF00);

    // Reset mid-window with rdy and overrun set.
    ack_mode = 0; l_const = 1'b1; r_const = 1'b1; drive();
    wait_cmpl(2, "rst_cmpl");
    chk("pre_rst_rdy", 32'(stereo_pcm_rdy), 32'h1);
    chk("pre_rst_ovr", 32'(overrun), 32'h1);
    wait_win(50, "rst_win");
    aclr = 1'b0; tick();
    chk("rst_pcm", 32'(stereo_pcm), 32'h0);
    chk("rst_rdy", 32'(stereo_pcm_rdy), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    aclr = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 400) begin
      tick(); n++;
      if (stereo_pcm_rdy === 1'b1) seen = 1'b1;
    end
    chk("rst_rdy_edge", 32'(n), 32'(WINDOW + SYNC_STAGES));
    chk("rst_pcm_ffff", 32'(stereo_pcm), 32'hFFFF);

    // Random data, random ack/clear, occasional enable drops.
    data_mode = 2; ack_mode = 2; clr_rand = 1'b1; off = 0;
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (off > 0) begin
        off--;
        enable = (off == 0);
      end else if ($urandom_range(0, 299) == 0) begin
        off = $urandom_range(1, 20);
        enable = 1'b0;
      end
    end
    enable = 1'b1; clr_rand = 1'b0; ack_mode = 0; drive();
    repeat (3) tick();
    chk("sb_drain", 32'(sbq.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
